// File: rtl/spi_cmd_sequencer_if.sv
// Bus bundle for the SD-card init sequencer: Avalon-MM status/control port,
// command channel towards the card core, response channel back from it, irq.
interface spi_cmd_sequencer_if;
  // Handshakes: a word moves on a rising edge where valid and ready are both
  // high; the producer holds valid and its data stable until that edge.
  logic        avs_s0_write;
  logic        avs_s0_read;
  logic [2:0]  avs_s0_address;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic [39:0] cmd_dout;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [39:0] rsp_din;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        irq;

  modport slave (
    input  avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_writedata,
    output avs_s0_readdata,
    output cmd_dout, cmd_valid,
    input  cmd_ready,
    input  rsp_din, rsp_valid,
    output rsp_ready,
    output irq
  );

  modport master (
    output avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_writedata,
    input  avs_s0_readdata,
    input  cmd_dout, cmd_valid,
    output cmd_ready,
    output rsp_din, rsp_valid,
    input  rsp_ready,
    input  irq
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// SD-card SPI-mode init sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD58,
// with per-response timeout, bounded retries and an Avalon status register.
module spi_cmd_sequencer #(
  parameter logic [15:0] RESP_TIMEOUT = 16'd50000,
  parameter logic [7:0]  MAX_RETRY    = 8'd200
) (
  input  logic               csi_clk,
  input  logic               rsi_reset,
  spi_cmd_sequencer_if.slave bus,
  output logic [2:0]         dbg_state
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  state_t      state, next_state;
  logic [2:0]  step, next_step;
  logic [7:0]  retry, next_retry, retry_inc;
  logic [15:0] tmo_cnt;
  logic [7:0]  rsp_r1;
  logic [11:0] rsp_echo;
  logic        rsp_ccs;
  logic        done, error, ccs, irq_q;
  logic [3:0]  err_code, fail_code;
  logic        ccs_load;
  logic        reg_wr, start, irq_clr;
  logic [31:0] status;

  assign reg_wr  = bus.avs_s0_write && (bus.avs_s0_address == 3'd5);
  assign start   = reg_wr && bus.avs_s0_writedata[0];
  assign irq_clr = reg_wr && bus.avs_s0_writedata[1];

  always_comb begin
    next_state = state;
    next_step  = step;
    next_retry = retry;
    retry_inc  = retry + 8'd1;
    fail_code  = 4'd0;
    ccs_load   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        next_state = ST_ISSUE;
        next_step  = 3'd0;
        next_retry = 8'd0;
      end
      ST_ISSUE: if (bus.cmd_ready) next_state = ST_WAIT;
      ST_WAIT: begin
        if (bus.rsp_valid) next_state = ST_EVAL;
        else if (tmo_cnt == RESP_TIMEOUT - 16'd1) begin
          next_state = ST_FAIL;
          fail_code  = 4'd7;
        end
      end
      ST_EVAL: begin
        // Anything not explicitly accepted below ends the sequence in FAIL.
        next_state = ST_FAIL;
        case (step)
          3'd0: if (rsp_r1 == 8'h01) begin
            next_state = ST_ISSUE; next_step = 3'd1;
          end else fail_code = 4'd1;
          3'd1: if (rsp_r1 == 8'h01 && rsp_echo == 12'h1AA) begin
            next_state = ST_ISSUE; next_step = 3'd2;
          end else fail_code = 4'd2;
          3'd2: if (rsp_r1[7:1] == 7'd0) begin
            next_state = ST_ISSUE; next_step = 3'd3;
          end else fail_code = 4'd3;
          3'd3: begin
            if (rsp_r1 == 8'h00) begin
              next_state = ST_ISSUE; next_step = 3'd4;
            end else if (rsp_r1 == 8'h01) begin
              // Card still initialising: go round CMD55/ACMD41 again.
              next_retry = retry_inc;
              if (retry_inc == MAX_RETRY) fail_code = 4'd6;
              else begin
                next_state = ST_ISSUE; next_step = 3'd2;
              end
            end else fail_code = 4'd4;
          end
          default: if (rsp_r1 == 8'h00) begin
            next_state = ST_DONE; ccs_load = 1'b1;
          end else fail_code = 4'd5;
        endcase
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state    <= ST_IDLE;
      step     <= 3'd0;
      retry    <= 8'd0;
      tmo_cnt  <= 16'd0;
      rsp_r1   <= 8'd0;
      rsp_echo <= 12'd0;
      rsp_ccs  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      ccs      <= 1'b0;
      err_code <= 4'd0;
      irq_q    <= 1'b0;
    end else begin
      state   <= next_state;
      step    <= next_step;
      retry   <= next_retry;
      tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + 16'd1 : 16'd0;
      if (state == ST_WAIT && bus.rsp_valid) begin
        rsp_r1   <= bus.rsp_din[39:32];
        rsp_echo <= bus.rsp_din[11:0];
        rsp_ccs  <= bus.rsp_din[30];
      end
      if (state == ST_IDLE && start) begin
        done     <= 1'b0;
        error    <= 1'b0;
        ccs      <= 1'b0;
        err_code <= 4'd0;
      end
      if (ccs_load) ccs <= rsp_ccs;
      if (next_state == ST_FAIL && state != ST_FAIL) err_code <= fail_code;
      if (state == ST_DONE) done <= 1'b1;
      if (state == ST_FAIL) error <= 1'b1;
      // Completion outranks a clear landing in the same cycle.
      if (state == ST_DONE || state == ST_FAIL) irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  always_comb begin
    bus.cmd_dout = 40'd0;
    if (state == ST_ISSUE) begin
      case (step)
        3'd0:    bus.cmd_dout = {8'h40, 32'h0000_0000};
        3'd1:    bus.cmd_dout = {8'h48, 32'h0000_01AA};
        3'd2:    bus.cmd_dout = {8'h77, 32'h0000_0000};
        3'd3:    bus.cmd_dout = {8'h69, 32'h4000_0000};
        default: bus.cmd_dout = {8'h7A, 32'h0000_0000};
      endcase
    end
  end

  assign bus.cmd_valid = (state == ST_ISSUE);
  assign bus.rsp_ready = (state == ST_WAIT);
  assign bus.irq       = irq_q;
  assign status        = {16'd0, retry, ccs, err_code, error, done, state != ST_IDLE};
  assign bus.avs_s0_readdata = (bus.avs_s0_read && bus.avs_s0_address == 3'd5) ? status : 32'd0;
  assign dbg_state     = state;

  wire unused_bits = &{1'b0, bus.avs_s0_writedata[31:2], bus.rsp_din[31], bus.rsp_din[29:12]};
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: table of full init sequences plus
// hand-written stall/timeout and mid-sequence reset scenarios.
module tb_spi_cmd_sequencer;
  logic       csi_clk = 1'b0;
  logic       rsi_reset;
  logic [2:0] dbg_state;

  spi_cmd_sequencer_if bus();

  spi_cmd_sequencer #(.RESP_TIMEOUT(16'd10), .MAX_RETRY(8'd3)) dut (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 csi_clk = ~csi_clk;

  typedef struct {
    string      name;
    int         n;
    logic       done;
    logic       error;
    logic       ccs;
    logic [3:0] code;
    logic [7:0] retry;
  } vec_t;

  localparam int NV = 8;
  vec_t        vecs   [NV];
  logic [2:0]  v_step [NV][12];
  logic [39:0] v_rsp  [NV][12];

  int    n_checks = 0;
  int    n_pass   = 0;
  string cur      = "init";

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur, nm, act, exp);
  endtask

  function automatic logic [39:0] cmd_word(input logic [2:0] s);
    case (s)
      3'd0:    return 40'h40_0000_0000;
      3'd1:    return 40'h48_0000_01AA;
      3'd2:    return 40'h77_0000_0000;
      3'd3:    return 40'h69_4000_0000;
      default: return 40'h7A_0000_0000;
    endcase
  endfunction

  task automatic add_pair(input int v, input logic [2:0] s, input logic [39:0] r);
    v_step[v][vecs[v].n] = s;
    v_rsp[v][vecs[v].n]  = r;
    vecs[v].n = vecs[v].n + 1;
  endtask

  task automatic set_exp(input int v, input string nm, input logic d, input logic e,
                         input logic c, input logic [3:0] code, input logic [7:0] rt);
    vecs[v].name = nm; vecs[v].done = d; vecs[v].error = e;
    vecs[v].ccs = c; vecs[v].code = code; vecs[v].retry = rt;
  endtask

  task automatic write_reg(input logic [31:0] d);
    bus.avs_s0_write = 1'b1; bus.avs_s0_address = 3'd5; bus.avs_s0_writedata = d;
    @(negedge csi_clk);
    bus.avs_s0_write = 1'b0; bus.avs_s0_writedata = 32'd0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    bus.avs_s0_read = 1'b1; bus.avs_s0_address = a;
    #1;
    d = bus.avs_s0_readdata;
    bus.avs_s0_read = 1'b0;
  endtask

  // Accept one command, compare it, and optionally answer it one cycle later.
  task automatic serve(input logic [2:0] s, input logic [39:0] r, input bit give_rsp);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (bus.cmd_valid) ok = 1'b1;
      else @(negedge csi_clk);
    end
    check("cmd_seen", ok, 1);
    if (ok) begin
      check("cmd_word", bus.cmd_dout, cmd_word(s));
      bus.cmd_ready = 1'b1;
      @(negedge csi_clk);
      bus.cmd_ready = 1'b0;
      check("rsp_ready_wait", bus.rsp_ready, 1);
      if (give_rsp) begin
        bus.rsp_din = r; bus.rsp_valid = 1'b1;
        @(negedge csi_clk);
        bus.rsp_valid = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input int v);
    logic [31:0] st;
    bit          idle;
    cur = vecs[v].name;
    write_reg(32'h1);
    check("cmd_valid_next", bus.cmd_valid, 1);
    read_reg(3'd5, st);
    check("start_status", st, 32'h1);
    write_reg(32'h2);
    check("irq_clr_busy", bus.irq, 0);
    for (int k = 0; k < vecs[v].n; k++) serve(v_step[v][k], v_rsp[v][k], 1'b1);
    idle = 1'b0;
    for (int c = 0; c < 20 && !idle; c++) begin
      read_reg(3'd5, st);
      if (st[0] == 1'b0) idle = 1'b1;
      else @(negedge csi_clk);
    end
    check("idle_seen", idle, 1);
    check("status", st, {16'h0, vecs[v].retry, vecs[v].ccs, vecs[v].code,
                         vecs[v].error, vecs[v].done, 1'b0});
    check("irq_set", bus.irq, 1);
    @(negedge csi_clk);
    check("no_extra_cmd", bus.cmd_valid, 0);
  endtask

  initial begin
    logic [31:0] st;
    rsi_reset = 1'b1;
    bus.avs_s0_write = 1'b0; bus.avs_s0_read = 1'b0; bus.avs_s0_address = 3'd0;
    bus.avs_s0_writedata = 32'd0; bus.cmd_ready = 1'b0;
    bus.rsp_din = 40'd0; bus.rsp_valid = 1'b0;
    repeat (3) @(negedge csi_clk);
    rsi_reset = 1'b0;

    cur = "reset";
    read_reg(3'd5, st);
    check("status", st, 32'h0);
    check("cmd_valid", bus.cmd_valid, 0);
    check("cmd_dout", bus.cmd_dout, 40'h0);
    check("rsp_ready", bus.rsp_ready, 0);
    check("irq", bus.irq, 0);
    check("state", dbg_state, 3'd0);
    read_reg(3'd4, st);
    check("other_addr", st, 32'h0);
    @(negedge csi_clk);

    for (int v = 0; v < NV; v++) vecs[v].n = 0;
    set_exp(0, "happy", 1, 0, 1, 4'd0, 8'd0);
    add_pair(0, 0, 40'h01_0000_0000); add_pair(0, 1, 40'h01_0000_01AA);
    add_pair(0, 2, 40'h01_0000_0000); add_pair(0, 3, 40'h00_0000_0000);
    add_pair(0, 4, 40'h00_C0FF_8000);
    set_exp(1, "cmd8_echo", 0, 1, 0, 4'd2, 8'd0);
    add_pair(1, 0, 40'h01_0000_0000); add_pair(1, 1, 40'h01_0000_01AB);
    set_exp(2, "retry_max", 0, 1, 0, 4'd6, 8'd3);
    add_pair(2, 0, 40'h01_0000_0000); add_pair(2, 1, 40'h01_0000_01AA);
    for (int i = 0; i < 3; i++) begin
      add_pair(2, 2, 40'h01_0000_0000); add_pair(2, 3, 40'h01_0000_0000);
    end
    set_exp(3, "cmd0_bad", 0, 1, 0, 4'd1, 8'd0);
    add_pair(3, 0, 40'h05_0000_0000);
    set_exp(4, "cmd55_bad", 0, 1, 0, 4'd3, 8'd0);
    add_pair(4, 0, 40'h01_0000_0000); add_pair(4, 1, 40'h01_0000_01AA);
    add_pair(4, 2, 40'h04_0000_0000);
    set_exp(5, "acmd41_bad", 0, 1, 0, 4'd4, 8'd0);
    add_pair(5, 0, 40'h01_0000_0000); add_pair(5, 1, 40'h01_0000_01AA);
    add_pair(5, 2, 40'h01_0000_0000); add_pair(5, 3, 40'h05_0000_0000);
    set_exp(6, "cmd58_bad", 0, 1, 0, 4'd5, 8'd0);
    add_pair(6, 0, 40'h01_0000_0000); add_pair(6, 1, 40'h01_0000_01AA);
    add_pair(6, 2, 40'h01_0000_0000); add_pair(6, 3, 40'h00_0000_0000);
    add_pair(6, 4, 40'h01_0000_0000);
    set_exp(7, "one_retry_sdsc", 1, 0, 0, 4'd0, 8'd1);
    add_pair(7, 0, 40'h01_0000_0000); add_pair(7, 1, 40'h01_0000_01AA);
    add_pair(7, 2, 40'h01_0000_0000); add_pair(7, 3, 40'h01_0000_0000);
    add_pair(7, 2, 40'h00_0000_0000); add_pair(7, 3, 40'h00_0000_0000);
    add_pair(7, 4, 40'h00_80FF_8000);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Command back-pressure, early response ignored, then response timeout.
    cur = "stall_timeout";
    write_reg(32'h1);
    bus.rsp_din = 40'h01_0000_0000; bus.rsp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("cmd_hold", bus.cmd_dout, 40'h40_0000_0000);
      check("rsp_ready_issue", bus.rsp_ready, 0);
      @(negedge csi_clk);
    end
    bus.rsp_valid = 1'b0;
    check("still_issue", dbg_state, 3'd1);
    bus.cmd_ready = 1'b1;
    @(negedge csi_clk);
    bus.cmd_ready = 1'b0;
    check("enter_wait", dbg_state, 3'd2);
    repeat (9) @(negedge csi_clk);
    check("wait_10th", dbg_state, 3'd2);
    @(negedge csi_clk);
    check("timeout_fail", dbg_state, 3'd5);
    @(negedge csi_clk);
    read_reg(3'd5, st);
    check("status", st, 32'h0000_003C);
    check("irq_set", bus.irq, 1);
    @(negedge csi_clk);

    // Reset while waiting on ACMD41, with a start attempt ignored while busy.
    cur = "reset_mid";
    write_reg(32'h1);
    serve(3'd0, 40'h01_0000_0000, 1'b1);
    write_reg(32'h1);
    serve(3'd1, 40'h01_0000_01AA, 1'b1);
    serve(3'd2, 40'h01_0000_0000, 1'b1);
    serve(3'd3, 40'h0, 1'b0);
    check("in_wait", dbg_state, 3'd2);
    rsi_reset = 1'b1;
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    read_reg(3'd5, st);
    check("status", st, 32'h0);
    check("irq", bus.irq, 0);
    check("rsp_ready", bus.rsp_ready, 0);
    check("cmd_dout", bus.cmd_dout, 40'h0);
    repeat (3) @(negedge csi_clk);
    check("no_reissue", bus.cmd_valid, 0);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end
endmodule
